// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Latency: n/a (types, encodings and the iteration-count helper only).
// Backpressure: n/a.
// Contents: op encodings, FSM state encodings, iteration-count function.
package mdu_pkg;

  // Encoding of the op input, in instruction order.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MUL   = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_RUN = 3'd1,
    ST_DIV_RUN = 3'd2,
    ST_FIX     = 3'd3,
    ST_DONE    = 3'd4
  } mdu_state_e;

  // Number of run-state cycles: one per divide bit, or one per
  // MUL_STEP-bit multiplier digit.
  function automatic int mdu_iters(input int width, input int mul_step, input bit is_div);
    return is_div ? width : (width / mul_step);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-division datapath: one quotient bit per step, MSB first.
// Latency: load, then WIDTH steps; o_last is high during the final step.
// Backpressure: none; advances only on cycles with i_step high.
// Ports:
//   i_clk, i_reset       clock, async active-high reset
//   i_load               capture dividend/divisor magnitudes, clear remainder/counter
//   i_step               retire one quotient bit
//   i_dividend, i_divisor unsigned magnitudes
//   o_last               the current step is the final one
//   o_quot, o_rem        unsigned quotient and remainder (valid after the last step)
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  localparam int DIV_ITERS = mdu_iters(WIDTH, 1, 1'b1);
  localparam int CNT_W     = $clog2(DIV_ITERS) + 1;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;   // dividend shifts out the top as quotient bits shift in
  logic [WIDTH-1:0] r_dsor;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  always_comb begin
    w_shift = {r_rem, r_quot[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_dsor});
    // When w_ge holds the true difference is below the divisor, so the
    // low WIDTH bits are exact.
    w_sub   = w_shift[WIDTH-1:0] - r_dsor;
    o_last  = (r_cnt == CNT_W'(DIV_ITERS - 1));
    o_quot  = r_quot;
    o_rem   = r_rem;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dsor <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dsor <= i_divisor;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_rem  <= w_ge ? w_sub : w_shift[WIDTH-1:0];
      r_quot <= {r_quot[WIDTH-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdu_hilo_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Latency: multiply done in cycle WIDTH/MUL_STEP+2 after start, divide in WIDTH+2; MTHI/MTLO write at the start edge.
// Backpressure: busy high while in flight; start is ignored while busy, no queueing.
// Build option: MDU_BYPASS_EN - hi/lo show the completing result during the done
//   cycle, and MTHI/MTLO issued in that cycle is dropped.
// Ports:
//   i_clk, i_reset          clock, async active-high reset (aborts everything)
//   i_start, i_op           issue strobe and mdu_op_e opcode
//   i_a, i_b, i_rd_in       rs/rt operands, MUL destination register
//   i_cancel                flush the operation in flight (also drops a same-cycle start)
//   o_busy, o_done          in flight / one-cycle completion pulse
//   o_wb_gpr, o_rd_out      with done: write o_result to GPR o_rd_out
//   o_result                low product word
//   o_dz                    divide-by-zero flag of the last completed divide
//   o_hi, o_lo              architectural HI/LO
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4,
  parameter int RD_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [RD_W-1:0]  i_rd_in,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wb_gpr,
  output logic [RD_W-1:0]  o_rd_out,
  output logic [WIDTH-1:0] o_result,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int MUL_ITERS = mdu_iters(WIDTH, MUL_STEP, 1'b0);
  localparam int MCNT_W    = $clog2(MUL_ITERS) + 1;

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;

  mdu_op_e          w_op;
  logic             w_in_done;
  logic             w_go;
  logic             w_issue_mul;
  logic             w_issue_div;
  logic             w_mt_ok;
  logic             w_commit;
  logic             w_op_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_step;
  logic             w_div_last;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Multiplier datapath
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [MCNT_W-1:0]  r_mcnt;
  logic [2*WIDTH-1:0] w_pp;
  logic               w_mul_last;

  // Per-operation context and results
  logic             r_neg;       // product sign
  logic             r_qneg;      // quotient sign
  logic             r_rneg;      // remainder sign (follows dividend)
  logic             r_dz_pend;   // divisor was zero
  logic             r_is_mul;    // MUL: GPR writeback
  logic             r_is_div;
  logic [RD_W-1:0]  r_rd;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dz;

  // Issue decode. A start is taken in IDLE or DONE (back-to-back), never
  // together with cancel.
  always_comb begin
    w_op        = mdu_op_e'(i_op);
    w_in_done   = (r_state == ST_DONE);
    w_go        = i_start && !i_cancel && ((r_state == ST_IDLE) || w_in_done);
    w_issue_mul = w_go && ((w_op == MDU_MULT) || (w_op == MDU_MULTU) || (w_op == MDU_MUL));
    w_issue_div = w_go && ((w_op == MDU_DIV) || (w_op == MDU_DIVU));
`ifdef MDU_BYPASS_EN
    // hi/lo are already forwarded in DONE; a same-cycle MTHI/MTLO would
    // make the forwarded value stale, so it is refused there.
    w_mt_ok     = w_go && !w_in_done;
`else
    w_mt_ok     = w_go;
`endif
    w_commit    = w_in_done && !i_cancel;
    w_op_signed = (w_op == MDU_MULT) || (w_op == MDU_MUL) || (w_op == MDU_DIV);
    w_a_neg     = w_op_signed && i_a[WIDTH-1];
    w_b_neg     = w_op_signed && i_b[WIDTH-1];
    // |MIN| = 2^(WIDTH-1) still fits as an unsigned magnitude.
    w_a_mag     = w_a_neg ? -i_a : i_a;
    w_b_mag     = w_b_neg ? -i_b : i_b;
  end

  // One radix-2^MUL_STEP digit per cycle: sum of shifted multiplicands.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (r_mplr[j]) begin
        w_pp = w_pp + (r_mcand << j);
      end
    end
    w_mul_last = (r_mcnt == MCNT_W'(MUL_ITERS - 1));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_div_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue_mul) begin
          w_state_nxt = ST_MUL_RUN;
        end else if (w_issue_div) begin
          w_state_nxt = ST_DIV_RUN;
        end
      end
      ST_MUL_RUN: begin
        o_busy = 1'b1;
        if (i_cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (w_mul_last) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_DIV_RUN: begin
        o_busy     = 1'b1;
        w_div_step = 1'b1;
        if (i_cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (w_div_last) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        o_busy      = 1'b1;
        w_state_nxt = i_cancel ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        o_done = !i_cancel;
        if (w_issue_mul) begin
          w_state_nxt = ST_MUL_RUN;
        end else if (w_issue_div) begin
          w_state_nxt = ST_DIV_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_issue_div),
    .i_step     (w_div_step),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_last     (w_div_last),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_mcnt    <= '0;
      r_neg     <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz_pend <= 1'b0;
      r_is_mul  <= 1'b0;
      r_is_div  <= 1'b0;
      r_rd      <= '0;
      r_res_hi  <= '0;
      r_res_lo  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dz      <= 1'b0;
    end else begin
      if (w_issue_mul) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplr   <= w_b_mag;
        r_mcnt   <= '0;
        r_neg    <= w_a_neg ^ w_b_neg;
        r_is_mul <= (w_op == MDU_MUL);
        r_is_div <= 1'b0;
        r_rd     <= i_rd_in;
      end else if (w_issue_div) begin
        r_qneg    <= w_a_neg ^ w_b_neg;
        r_rneg    <= w_a_neg;
        r_dz_pend <= (i_b == '0);
        r_is_mul  <= 1'b0;
        r_is_div  <= 1'b1;
      end

      if (r_state == ST_MUL_RUN) begin
        r_acc   <= r_acc + w_pp;
        r_mcand <= r_mcand << MUL_STEP;
        r_mplr  <= r_mplr >> MUL_STEP;
        r_mcnt  <= r_mcnt + 1'b1;
      end

      // Sign correction. A zero divisor yields an all-ones magnitude
      // quotient, forced to all ones regardless of sign; the remainder is
      // |a| re-signed, i.e. a itself.
      if (r_state == ST_FIX) begin
        if (r_is_div) begin
          r_res_lo <= r_dz_pend ? '1 : (r_qneg ? -w_quot : w_quot);
          r_res_hi <= r_rneg ? -w_rem : w_rem;
        end else begin
          {r_res_hi, r_res_lo} <= r_neg ? -r_acc : r_acc;
        end
      end

      // Completion commit first, then MTHI/MTLO so that a move issued in
      // the DONE cycle overrides the completing value of its register.
      if (w_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
        if (r_is_div) begin
          r_dz <= r_dz_pend;
        end
      end
      if (w_mt_ok && (w_op == MDU_MTHI)) begin
        r_hi <= i_a;
      end
      if (w_mt_ok && (w_op == MDU_MTLO)) begin
        r_lo <= i_a;
      end
    end
  end

  assign o_wb_gpr = o_done && r_is_mul;
  assign o_rd_out = r_rd;
  assign o_result = r_res_lo;
  assign o_dz     = r_dz;

`ifdef MDU_BYPASS_EN
  assign o_hi = w_commit ? r_res_hi : r_hi;
  assign o_lo = w_commit ? r_res_lo : r_lo;
`else
  assign o_hi = r_hi;
  assign o_lo = r_lo;
`endif

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit (WIDTH=32, MUL_STEP=4, RD_W=5).
// An arithmetic reference model predicts busy/done/hi/lo/dz each cycle;
// directed vectors add hand-computed literal checks.
module tb_mdu_hilo_unit;

  localparam int W  = 32;
  localparam int MS = 4;

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic         start  = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op     = 3'd0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic [4:0]   rd_in  = '0;

  logic         busy, done, wb_gpr, dz;
  logic [4:0]   rd_out;
  logic [W-1:0] result, hi, lo;

  always #5 clk = ~clk;

  mdu_hilo_unit #(.WIDTH(W), .MUL_STEP(MS), .RD_W(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_rd_in(rd_in), .i_cancel(cancel), .o_busy(busy), .o_done(done),
    .o_wb_gpr(wb_gpr), .o_rd_out(rd_out), .o_result(result), .o_dz(dz),
    .o_hi(hi), .o_lo(lo)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  bit           m_pend = 0;
  int           m_done_at = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  bit           m_dz = 0, m_rdz = 0, m_is_div = 0, m_is_mul = 0;
  logic [4:0]   m_rd = '0;

  // Observed completions
  int           seen_done_cyc = -1;
  int           done_cnt = 0;
  logic         seen_wb = 1'b0;
  logic [4:0]   seen_rd = '0;
  logic [W-1:0] seen_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain-arithmetic result of an operation: {hi, lo} and divide-by-zero.
  function automatic void calc(input logic [2:0] fo, input logic [W-1:0] fa, input logic [W-1:0] fb,
                               output logic [W-1:0] rh, output logic [W-1:0] rl, output bit rdz);
    longint      sa, sb;
    logic [63:0] p;
    sa  = longint'($signed(fa));
    sb  = longint'($signed(fb));
    rdz = 0;
    rh  = '0;
    rl  = '0;
    case (fo)
      3'd0, 3'd4: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
      3'd1:       begin p = {32'b0, fa} * {32'b0, fb}; rh = p[63:32]; rl = p[31:0]; end
      3'd2, 3'd3: begin
        if (fb == '0) begin
          rdz = 1; rl = '1; rh = fa;
        end else if (fo == 3'd2) begin
          rl = 32'(sa / sb); rh = 32'(sa % sb);
        end else begin
          rl = fa / fb; rh = fa % fb;
        end
      end
      default: ;
    endcase
  endfunction

  // Model advance at each rising edge, from the inputs the DUT samples.
  task automatic model_step();
    bit           in_done, busy_now, mt_blocked;
    logic [W-1:0] rh, rl;
    bit           rdz;
    in_done    = m_pend && (cyc == m_done_at);
    busy_now   = m_pend && (cyc < m_done_at);
    mt_blocked = 0;
`ifdef MDU_BYPASS_EN
    mt_blocked = in_done;
`endif
    if (reset) begin
      m_pend = 0; m_hi = '0; m_lo = '0; m_dz = 0;
    end else if (cancel) begin
      if (busy_now || in_done) m_pend = 0;
    end else begin
      if (in_done) begin
        m_hi = m_rhi; m_lo = m_rlo;
        if (m_is_div) m_dz = m_rdz;
        m_pend = 0;
      end
      if (start && !busy_now) begin
        if (op <= 3'd4) begin
          calc(op, a, b, rh, rl, rdz);
          m_rhi = rh; m_rlo = rl; m_rdz = rdz;
          m_is_div  = (op == 3'd2) || (op == 3'd3);
          m_is_mul  = (op == 3'd4);
          m_rd      = rd_in;
          m_pend    = 1;
          m_done_at = cyc + (m_is_div ? W : W / MS) + 2;
        end else if (op == 3'd5 && !mt_blocked) begin
          m_hi = a;
        end else if (op == 3'd6 && !mt_blocked) begin
          m_lo = a;
        end
      end
    end
    cyc++;
  endtask

  // Every-cycle comparison against the model.
  task automatic compare_step();
    bit           in_done, e_busy, e_done, e_dz;
    logic [W-1:0] e_hi, e_lo;
    in_done = m_pend && (cyc == m_done_at);
    e_busy  = m_pend && (cyc < m_done_at);
    e_done  = in_done && !cancel;
    e_hi    = m_hi;
    e_lo    = m_lo;
    e_dz    = m_dz;
`ifdef MDU_BYPASS_EN
    if (e_done) begin e_hi = m_rhi; e_lo = m_rlo; end
`endif
    if (reset) begin
      e_busy = 0; e_done = 0; e_hi = '0; e_lo = '0; e_dz = 0;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("hi", hi, e_hi);
    chk("lo", lo, e_lo);
    chk("dz", dz, e_dz);
    chk("wb_gpr", wb_gpr, e_done && m_is_mul);
    if (e_done && m_is_mul) begin
      chk("rd_out", rd_out, m_rd);
      chk("result", result, m_rlo);
    end
    if (done) begin
      done_cnt++;
      seen_done_cyc = cyc;
      seen_wb  = wb_gpr;
      seen_rd  = rd_out;
      seen_res = result;
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); compare_step(); end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [4:0] r, output int t);
    op = o; a = x; b = y; rd_in = r; start = 1'b1; t = cyc;
    tick(1);
    start = 1'b0;
  endtask

  initial begin : stim
    int t, d0;
    tick(2);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_dz", dz, 0);

    issue(3'd5, 32'h1234, 0, 0, t);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234); chk("mthi_busy", busy, 0);

    // Reset in cycle 5 of a divide
    d0 = done_cnt;
    issue(3'd2, 100, 7, 0, t);
    tick(4);
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    @(negedge clk);
    chk("rstdiv_busy", busy, 0); chk("rstdiv_hi", hi, 0); chk("rstdiv_lo", lo, 0);
    tick(40);
    chk("rstdiv_nodone", done_cnt - d0, 0);

    issue(3'd0, 32'hFFFFFFFF, 2, 0, t); tick(10);
    @(negedge clk);
    chk("mult_lat", seen_done_cyc - t, 10);
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFE);

    issue(3'd1, 32'hFFFFFFFF, 2, 0, t); tick(10);
    @(negedge clk);
    chk("multu_hi", hi, 32'h00000001); chk("multu_lo", lo, 32'hFFFFFFFE);

    issue(3'd2, 32'hFFFFFFF9, 2, 0, t); tick(34);
    @(negedge clk);
    chk("div_lat", seen_done_cyc - t, 34);
    chk("div_lo", lo, 32'hFFFFFFFD); chk("div_hi", hi, 32'hFFFFFFFF); chk("div_dz", dz, 0);

    issue(3'd3, 5, 0, 0, t); tick(34);
    @(negedge clk);
    chk("dz_flag", dz, 1); chk("dz_lo", lo, 32'hFFFFFFFF); chk("dz_hi", hi, 5);

    issue(3'd3, 9, 3, 0, t); tick(34);
    @(negedge clk);
    chk("divu_dz", dz, 0); chk("divu_lo", lo, 3); chk("divu_hi", hi, 0);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, t); tick(34);
    @(negedge clk);
    chk("ovf_lo", lo, 32'h80000000); chk("ovf_hi", hi, 0); chk("ovf_dz", dz, 0);

    // MUL cancelled in cycle 4
    d0 = done_cnt;
    issue(3'd4, 6, 7, 9, t);
    tick(3);
    cancel = 1'b1; tick(1); cancel = 1'b0;
    tick(12);
    @(negedge clk);
    chk("cancel_nodone", done_cnt - d0, 0);
    chk("cancel_hi", hi, 0); chk("cancel_lo", lo, 32'h80000000);

    issue(3'd4, 6, 7, 9, t); tick(10);
    @(negedge clk);
    chk("mul_lat", seen_done_cyc - t, 10);
    chk("mul_wb", seen_wb, 1); chk("mul_rd", seen_rd, 9); chk("mul_res", seen_res, 42);
    chk("mul_lo", lo, 42); chk("mul_hi", hi, 0);

    // MULTU 3x4, then MTLO issued in its DONE cycle
    issue(3'd1, 3, 4, 0, t);
    tick(9);
    op = 3'd6; a = 32'h55; start = 1'b1;
    @(negedge clk);
    chk("b2b_done", done, 1);
`ifdef MDU_BYPASS_EN
    chk("b2b_lo_in_done", lo, 12);
`else
    chk("b2b_lo_in_done", lo, 42);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
`ifdef MDU_BYPASS_EN
    chk("b2b_lo", lo, 12);
`else
    chk("b2b_lo", lo, 32'h55);
`endif
    chk("b2b_hi", hi, 0);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
